// File: rtl/croma_ctrl_rpt.sv
// croma_ctrl_rpt: screen tone, letter colour and background colour registers
// stepped by the UP/down push-buttons, with synchronisation, press-edge
// detection, hold-to-auto-repeat, saturation and a one-cycle update strobe.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for a key press edge
// S_DELAY    | key held after the first step, waiting for auto-repeat to begin
// S_REPEAT   | auto-repeat active, stepping every REPEAT_RATE cycles
// S_WAIT_REL | conflict seen (both keys / target changed), wait for release
module croma_ctrl_rpt #(
   parameter int                 TONE_W      = 8,
   parameter int                 COLOR_W     = 3,
   parameter logic [TONE_W-1:0]  TONE_RST    = TONE_W'(8'hA4),
   parameter logic [COLOR_W-1:0] COLORL_RST  = '0,
   parameter logic [COLOR_W-1:0] COLORP_RST  = COLOR_W'(2**COLOR_W-1),
   parameter int                 REPEAT_DLY  = 25000000,
   parameter int                 REPEAT_RATE = 5000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               UP,
   input  logic               down,
   input  logic [1:0]         sel,
   output logic [TONE_W-1:0]  ton,
   output logic [COLOR_W-1:0] ColorL,
   output logic [COLOR_W-1:0] ColorP,
   output logic               upd
);

   localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   // The counter restarts at 0 on every step, so matching on N-1 places
   // consecutive steps exactly N cycles apart (REPEAT_RATE=1 steps every cycle).
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DELAY    = 2'd1,
      S_REPEAT   = 2'd2,
      S_WAIT_REL = 2'd3
   } state_t;

   logic               u_meta_q, u_s_q, u_p_q;
   logic               d_meta_q, d_s_q, d_p_q;
   logic [1:0]         sel_meta_q, sel_s_q;

   state_t             state_q;
   logic               key_up_q;
   logic [1:0]         sel_l_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [TONE_W-1:0]  ton_q;
   logic [COLOR_W-1:0] color_l_q;
   logic [COLOR_W-1:0] color_p_q;
   logic               upd_q;

   logic               press_u, press_d;
   logic               key_held, other_key, sel_moved;
   logic               step_up;
   logic [CNT_W-1:0]   cnt_last;
   logic [TONE_W-1:0]  ton_step;
   logic [COLOR_W-1:0] color_l_step;
   logic [COLOR_W-1:0] color_p_step;
   logic               step_chg;

   assign press_u   = u_s_q & ~u_p_q;
   assign press_d   = d_s_q & ~d_p_q;
   assign key_held  = key_up_q ? u_s_q : d_s_q;
   assign other_key = key_up_q ? d_s_q : u_s_q;
   assign sel_moved = (sel_s_q != sel_l_q);
   assign step_up   = (state_q == S_IDLE) ? u_s_q : key_up_q;
   assign cnt_last  = (state_q == S_DELAY) ? DLY_LAST : RATE_LAST;

   // Two-flop synchronisers for the asynchronous keys and selector, plus the
   // extra key stage used for press-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         u_meta_q   <= 1'b0;
         u_s_q      <= 1'b0;
         u_p_q      <= 1'b0;
         d_meta_q   <= 1'b0;
         d_s_q      <= 1'b0;
         d_p_q      <= 1'b0;
         sel_meta_q <= 2'b00;
         sel_s_q    <= 2'b00;
      end else begin
         u_meta_q   <= UP;
         u_s_q      <= u_meta_q;
         u_p_q      <= u_s_q;
         d_meta_q   <= down;
         d_s_q      <= d_meta_q;
         d_p_q      <= d_s_q;
         sel_meta_q <= sel;
         sel_s_q    <= sel_meta_q;
      end
   end

   // Candidate values if a step were taken now: only the selected register
   // moves, and it saturates at 0 / all-ones instead of wrapping.
   always_comb begin
      ton_step     = ton_q;
      color_l_step = color_l_q;
      color_p_step = color_p_q;
      case (sel_s_q)
         2'b00: begin
            if (step_up) begin
               if (color_p_q != {COLOR_W{1'b1}}) color_p_step = color_p_q + COLOR_W'(1);
            end else begin
               if (color_p_q != '0) color_p_step = color_p_q - COLOR_W'(1);
            end
         end
         2'b01: begin
            if (step_up) begin
               if (color_l_q != {COLOR_W{1'b1}}) color_l_step = color_l_q + COLOR_W'(1);
            end else begin
               if (color_l_q != '0) color_l_step = color_l_q - COLOR_W'(1);
            end
         end
         2'b10: begin
            if (step_up) begin
               if (ton_q != {TONE_W{1'b1}}) ton_step = ton_q + TONE_W'(1);
            end else begin
               if (ton_q != '0) ton_step = ton_q - TONE_W'(1);
            end
         end
         default: ;
      endcase
      step_chg = (ton_step != ton_q) || (color_l_step != color_l_q) ||
                 (color_p_step != color_p_q);
   end

   // Key-handling FSM with the repeat counter and the registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         key_up_q  <= 1'b0;
         sel_l_q   <= 2'b00;
         cnt_q     <= '0;
         ton_q     <= TONE_RST;
         color_l_q <= COLORL_RST;
         color_p_q <= COLORP_RST;
         upd_q     <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (u_s_q && d_s_q) begin
                  state_q <= S_WAIT_REL;
               end else if (press_u || press_d) begin
                  ton_q     <= ton_step;
                  color_l_q <= color_l_step;
                  color_p_q <= color_p_step;
                  upd_q     <= step_chg;
                  key_up_q  <= u_s_q;
                  sel_l_q   <= sel_s_q;
                  state_q   <= S_DELAY;
               end
            end
            S_DELAY, S_REPEAT: begin
               if (!key_held) begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else if (other_key || sel_moved) begin
                  cnt_q   <= '0;
                  state_q <= S_WAIT_REL;
               end else if (cnt_q == cnt_last) begin
                  ton_q     <= ton_step;
                  color_l_q <= color_l_step;
                  color_p_q <= color_p_step;
                  upd_q     <= step_chg;
                  cnt_q     <= '0;
                  state_q   <= S_REPEAT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_WAIT_REL: begin
               cnt_q <= '0;
               if (!u_s_q && !d_s_q) state_q <= S_IDLE;
            end
            default: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ton    = ton_q;
   assign ColorL = color_l_q;
   assign ColorP = color_p_q;
   assign upd    = upd_q;

endmodule

// File: tb/tb_croma_ctrl_rpt.sv
// Testbench for croma_ctrl_rpt: table-driven key sequences, hand-written
// conflict / reset sequences and a randomized run, all checked against a
// cycle-level reference model built from the step-timing rules.
module tb_croma_ctrl_rpt;

   localparam int DLY  = 8;
   localparam int RATE = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       UP, down;
   logic [1:0] sel;
   logic [7:0] ton;
   logic [2:0] ColorL, ColorP;
   logic       upd;

   int checks  = 0;
   int errors  = 0;
   int upd_cnt = 0;

   croma_ctrl_rpt #(
      .TONE_W      (8),
      .COLOR_W     (3),
      .REPEAT_DLY  (DLY),
      .REPEAT_RATE (RATE)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .UP     (UP),
      .down   (down),
      .sel    (sel),
      .ton    (ton),
      .ColorL (ColorL),
      .ColorP (ColorP),
      .upd    (upd)
   );

   always #5 clk = ~clk;

   // Reference model: keys/selector become visible two edges after being
   // sampled; a press steps at once, a continuous clean hold steps again at
   // age DLY and then every RATE cycles.
   bit   [2:0] hu, hd;
   logic [1:0] hs0, hs1;
   int         m_ton, m_cl, m_cp, m_mode, m_age;
   bit         m_upd, m_key;
   logic [1:0] m_sel;

   always @(posedge clk or posedge reset) begin : model
      int nt, nl, np, nmode, nage;
      bit stp, dir, us, upk, ds, dpk, nkey;
      logic [1:0] ss, nsel;
      if (reset) begin
         hu <= '0; hd <= '0; hs0 <= '0; hs1 <= '0;
         m_ton <= 'hA4; m_cl <= 0; m_cp <= 7; m_upd <= 1'b0;
         m_mode <= 0; m_age <= 0; m_key <= 1'b0; m_sel <= '0;
      end else begin
         us = hu[1]; upk = hu[2]; ds = hd[1]; dpk = hd[2]; ss = hs1;
         nt = m_ton; nl = m_cl; np = m_cp;
         nmode = m_mode; nage = m_age; nkey = m_key; nsel = m_sel;
         stp = 1'b0; dir = 1'b0;
         case (m_mode)
            0: begin
               if (us && ds) nmode = 2;
               else if ((us && !upk) || (ds && !dpk)) begin
                  stp = 1'b1; dir = us; nkey = us; nsel = ss; nage = 0; nmode = 1;
               end
            end
            1: begin
               if (!(m_key ? us : ds)) nmode = 0;
               else if ((m_key ? ds : us) || (ss != m_sel)) nmode = 2;
               else begin
                  nage = m_age + 1;
                  if (nage == DLY || (nage > DLY && (nage - DLY) % RATE == 0)) begin
                     stp = 1'b1; dir = m_key;
                  end
               end
            end
            default: if (!us && !ds) nmode = 0;
         endcase
         if (stp) begin
            case (ss)
               2'b00: np = dir ? ((np < 7) ? np + 1 : np) : ((np > 0) ? np - 1 : np);
               2'b01: nl = dir ? ((nl < 7) ? nl + 1 : nl) : ((nl > 0) ? nl - 1 : nl);
               2'b10: nt = dir ? ((nt < 255) ? nt + 1 : nt) : ((nt > 0) ? nt - 1 : nt);
               default: ;
            endcase
         end
         m_upd  <= (nt != m_ton) || (nl != m_cl) || (np != m_cp);
         m_ton  <= nt; m_cl <= nl; m_cp <= np;
         m_mode <= nmode; m_age <= nage; m_key <= nkey; m_sel <= nsel;
         hu  <= {hu[1:0], UP};
         hd  <= {hd[1:0], down};
         hs0 <= sel;
         hs1 <= hs0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: compare DUT against the model mid-cycle, then move to 1 ns
   // after the next rising edge where stimulus is driven.
   task automatic step_cycle();
      @(negedge clk);
      chk("model_ton", ton, m_ton);
      chk("model_colorl", ColorL, m_cl);
      chk("model_colorp", ColorP, m_cp);
      chk("model_upd", upd, m_upd);
      if (upd) upd_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step_cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      run(2);
   endtask

   typedef struct {
      bit         rst;
      bit         up;
      bit         dn;
      logic [1:0] sel;
      int         hold;
      int         e_ton;
      int         e_cl;
      int         e_cp;
      int         e_upd;
   } vec_t;

   vec_t vecs[12];
   int   c0;

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b10,  3, 'hA5, 0, 7, 1};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b10, 30, 'hAB, 0, 7, 7};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'b10,  1, 'hAA, 0, 7, 1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b01,  6, 'hAA, 1, 7, 1};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b01, 22, 'hAA, 6, 7, 5};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 40, 'hAA, 7, 7, 1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'b00, 40, 'hAA, 7, 0, 7};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'b00, 40, 'hAA, 7, 0, 0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b11, 12, 'hAA, 7, 0, 0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 2'b10, 10, 'hAA, 7, 0, 0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b00,  1, 'hAA, 7, 1, 1};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b01,  9, 'hAA, 5, 1, 2};

      reset = 1'b1; UP = 1'b0; down = 1'b0; sel = 2'b11;
      #3;
      chk("reset_ton", ton, 'hA4);
      chk("reset_colorl", ColorL, 0);
      chk("reset_colorp", ColorP, 7);
      chk("reset_upd", upd, 0);
      @(posedge clk); #1;
      run(2);
      reset = 1'b0;
      run(2);

      // table-driven key sequences
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].rst) do_reset();
         UP = vecs[i].up; down = vecs[i].dn; sel = vecs[i].sel;
         c0 = upd_cnt;
         run(vecs[i].hold);
         UP = 1'b0; down = 1'b0;
         run(8);
         chk($sformatf("vec%0d_ton", i), ton, vecs[i].e_ton);
         chk($sformatf("vec%0d_colorl", i), ColorL, vecs[i].e_cl);
         chk($sformatf("vec%0d_colorp", i), ColorP, vecs[i].e_cp);
         chk($sformatf("vec%0d_upd_count", i), upd_cnt - c0, vecs[i].e_upd);
      end

      // down asserted while UP is in its repeat delay: blocked until release
      do_reset();
      sel = 2'b10; UP = 1'b1;
      run(4);
      down = 1'b1;
      run(16);
      chk("conflict_blocked_ton", ton, 'hA5);
      UP = 1'b0; down = 1'b0;
      run(6);
      UP = 1'b1;
      run(2);
      UP = 1'b0;
      run(6);
      chk("conflict_repress_ton", ton, 'hA6);

      // selector moves from letters to background during auto-repeat
      do_reset();
      sel = 2'b01; UP = 1'b1;
      run(14);
      sel = 2'b00;
      run(3);
      chk("selchg_colorl_early", ColorL, 3);
      run(20);
      chk("selchg_colorl_late", ColorL, 3);
      chk("selchg_colorp", ColorP, 7);
      chk("selchg_ton", ton, 'hA4);
      UP = 1'b0;
      run(6);

      // reset in the middle of an auto-repeat, key still held afterwards
      do_reset();
      sel = 2'b10; UP = 1'b1;
      run(51);
      chk("midrst_before_ton", ton, 'hB0);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_async_ton", ton, 'hA4);
      chk("midrst_async_colorl", ColorL, 0);
      chk("midrst_async_colorp", ColorP, 7);
      chk("midrst_async_upd", upd, 0);
      run(1);
      reset = 1'b0;
      run(2);
      chk("midrst_hold_ton", ton, 'hA4);
      run(1);
      chk("midrst_step_ton", ton, 'hA5);
      chk("midrst_step_upd", upd, 1);
      UP = 1'b0;
      run(6);

      // randomized key activity checked cycle by cycle against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 11) == 0) UP = ~UP;
         if ($urandom_range(0, 11) == 0) down = ~down;
         if ($urandom_range(0, 59) == 0) sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1499) == 0) begin
            reset = 1'b1;
            run(1);
            reset = 1'b0;
         end
         step_cycle();
      end
      UP = 1'b0; down = 1'b0;
      run(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
